// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780 frame writer.
//   - HD44780 command bytes used by init and line addressing
//   - sequencer and byte-writer state encodings
//   - init_cmd(): command byte for each step of the init sequence
package lcd_pkg;

   localparam logic [7:0] CMD_FUNCSET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
   localparam logic [7:0] CMD_DISPON  = 8'h0C;  // display on, cursor off
   localparam logic [7:0] CMD_CLEAR   = 8'h01;  // clear display (long execution time)
   localparam logic [7:0] CMD_ENTRY   = 8'h06;  // increment, no shift
   localparam logic [7:0] CMD_LINE1   = 8'h80;  // DDRAM address 0x00
   localparam logic [7:0] CMD_LINE2   = 8'hC0;  // DDRAM address 0x40

   localparam logic [3:0] INIT_LAST = 4'd4;     // five init commands, index 0..4
   localparam logic [3:0] CHAR_LAST = 4'd15;    // sixteen chars per line

   typedef enum logic [2:0] {
      ST_PWRUP, ST_INIT, ST_SNAP, ST_ADDR1, ST_CHR1, ST_ADDR2, ST_CHR2
   } lcd_state_e;

   typedef enum logic [1:0] {
      WR_IDLE, WR_SETUP, WR_PULSE, WR_WAIT
   } wr_state_e;

   function automatic logic [7:0] init_cmd(input logic [3:0] idx);
      case (idx)
         4'd0, 4'd1: init_cmd = CMD_FUNCSET;
         4'd2:       init_cmd = CMD_DISPON;
         4'd3:       init_cmd = CMD_CLEAR;
         default:    init_cmd = CMD_ENTRY;
      endcase
   endfunction

endpackage

// File: rtl/lcd_byte_writer.sv
// One HD44780 bus write: SETUP (1 cycle, EN=0), PULSE (N cycles, EN=1),
// WAIT (W cycles, EN=0). DATA/RS are held from SETUP through the end of WAIT
// and only change when a new write is accepted.
//   clk_i, clr_i        clock, synchronous active-high reset
//   start_i/byte_i/rs_i write request; ignored while busy_o
//   done_o              1-cycle pulse in the last WAIT cycle
//   busy_o              write in progress (drops in the done cycle so the next
//                       write can start back-to-back)
//   data_o/rs_o/en_o    LCD bus pins
module lcd_byte_writer
   import lcd_pkg::*;
#(
   parameter int EN_PULSE_CYCLES   = 25,
   parameter int CMD_WAIT_CYCLES   = 2000,
   parameter int CLEAR_WAIT_CYCLES = 82000
) (
   input  logic       clk_i,
   input  logic       clr_i,
   input  logic       start_i,
   input  logic [7:0] byte_i,
   input  logic       rs_i,
   output logic       done_o,
   output logic       busy_o,
   output logic [7:0] data_o,
   output logic       rs_o,
   output logic       en_o
);

   // A parameter of 0 behaves as 1.
   localparam int PULSE_N = (EN_PULSE_CYCLES   < 1) ? 1 : EN_PULSE_CYCLES;
   localparam int CMD_N   = (CMD_WAIT_CYCLES   < 1) ? 1 : CMD_WAIT_CYCLES;
   localparam int CLR_N   = (CLEAR_WAIT_CYCLES < 1) ? 1 : CLEAR_WAIT_CYCLES;
   localparam int MAX_AB  = (PULSE_N > CMD_N) ? PULSE_N : CMD_N;
   localparam int MAX_N   = (MAX_AB > CLR_N) ? MAX_AB : CLR_N;
   localparam int CNT_W   = $clog2(MAX_N + 1);

   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_N - 1);
   localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_N - 1);
   localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLR_N - 1);

   wr_state_e        st_q, st_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       data_q, data_d;
   logic             rs_q, rs_d;
   logic             long_q, long_d;   // current write is a clear-display
   logic             done, busy;

   always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      data_d = data_q;
      rs_d   = rs_q;
      long_d = long_q;
      done   = 1'b0;
      case (st_q)
         WR_SETUP: begin
            st_d  = WR_PULSE;
            cnt_d = '0;
         end
         WR_PULSE: begin
            if (cnt_q == PULSE_LAST) begin
               st_d  = WR_WAIT;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         WR_WAIT: begin
            if (cnt_q == (long_q ? CLR_LAST : CMD_LAST)) begin
               done  = 1'b1;
               st_d  = WR_IDLE;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
      busy = (st_q != WR_IDLE) && !done;
      // Accepting in the done cycle makes the next SETUP follow WAIT directly.
      if (start_i && !busy) begin
         st_d   = WR_SETUP;
         cnt_d  = '0;
         data_d = byte_i;
         rs_d   = rs_i;
         long_d = !rs_i && (byte_i == CMD_CLEAR);
      end
   end

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         st_q   <= WR_IDLE;
         cnt_q  <= '0;
         data_q <= '0;
         rs_q   <= 1'b0;
         long_q <= 1'b0;
      end else begin
         st_q   <= st_d;
         cnt_q  <= cnt_d;
         data_q <= data_d;
         rs_q   <= rs_d;
         long_q <= long_d;
      end
   end

   assign done_o = done;
   assign busy_o = busy;
   assign data_o = data_q;
   assign rs_o   = rs_q;
   assign en_o   = (st_q == WR_PULSE);

endmodule

// File: rtl/lcd_frame_writer.sv
// Drives a 16x2 HD44780 LCD over an 8-bit bus: power-up wait, init sequence
// once, then endless refresh of line 1 (LINE1) and line 2 (LINE2). Both lines
// are snapshotted once per frame so every frame is internally coherent.
//   CLK, CLR            clock, synchronous active-high reset
//   LINE1, LINE2        16 ASCII chars each, leftmost char in [127:120]
//   LCD_DATA/RS/RW/EN   LCD bus (RW tied 0, write only)
//   LCD_ON, LCD_BLON    constant 1
//   INIT_DONE           high after the init sequence until CLR
//   FRAME_DONE          1-cycle pulse when the last line-2 char finishes
module lcd_frame_writer
   import lcd_pkg::*;
#(
   parameter int POWERUP_CYCLES    = 750000,
   parameter int EN_PULSE_CYCLES   = 25,
   parameter int CMD_WAIT_CYCLES   = 2000,
   parameter int CLEAR_WAIT_CYCLES = 82000
) (
   input  logic         CLK,
   input  logic         CLR,
   input  logic [127:0] LINE1,
   input  logic [127:0] LINE2,
   output logic [7:0]   LCD_DATA,
   output logic         LCD_RS,
   output logic         LCD_RW,
   output logic         LCD_EN,
   output logic         LCD_ON,
   output logic         LCD_BLON,
   output logic         INIT_DONE,
   output logic         FRAME_DONE
);

   localparam int PWR_N = (POWERUP_CYCLES < 1) ? 1 : POWERUP_CYCLES;
   localparam int PWR_W = $clog2(PWR_N + 1);
   localparam logic [PWR_W-1:0] PWR_LAST = PWR_W'(PWR_N - 1);

   lcd_state_e       state_q, state_d;
   logic [PWR_W-1:0] pwr_q, pwr_d;
   logic [3:0]       idx_q, idx_d;
   logic             init_done_q, init_done_d;
   logic [127:0]     frame1_q, frame2_q;
   logic             frame_done;
   logic             wr_start, wr_rs, wr_done, wr_busy;
   logic [7:0]       wr_byte;

   always_comb begin
      state_d     = state_q;
      pwr_d       = pwr_q;
      idx_d       = idx_q;
      init_done_d = init_done_q;
      frame_done  = 1'b0;
      case (state_q)
         ST_PWRUP: begin
            if (pwr_q == PWR_LAST) begin
               state_d = ST_INIT;
               idx_d   = '0;
            end else begin
               pwr_d = pwr_q + 1'b1;
            end
         end
         ST_INIT: begin
            if (wr_done) begin
               if (idx_q == INIT_LAST) begin
                  state_d     = ST_SNAP;
                  idx_d       = '0;
                  init_done_d = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         ST_SNAP:  state_d = ST_ADDR1;
         ST_ADDR1: if (wr_done) begin state_d = ST_CHR1; idx_d = '0; end
         ST_CHR1: begin
            if (wr_done) begin
               if (idx_q == CHAR_LAST) state_d = ST_ADDR2;
               else                    idx_d   = idx_q + 1'b1;
            end
         end
         ST_ADDR2: if (wr_done) begin state_d = ST_CHR2; idx_d = '0; end
         ST_CHR2: begin
            if (wr_done) begin
               if (idx_q == CHAR_LAST) begin
                  state_d    = ST_SNAP;
                  idx_d      = '0;
                  frame_done = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: state_d = ST_PWRUP;
      endcase

      // The next write is chosen from the next state/index so it can be
      // handed over in the same cycle the previous write finishes.
      wr_byte  = '0;
      wr_rs    = 1'b0;
      wr_start = 1'b0;
      case (state_d)
         ST_INIT:  begin wr_start = 1'b1; wr_byte = init_cmd(idx_d); end
         ST_ADDR1: begin wr_start = 1'b1; wr_byte = CMD_LINE1; end
         ST_ADDR2: begin wr_start = 1'b1; wr_byte = CMD_LINE2; end
         ST_CHR1: begin
            wr_start = 1'b1;
            wr_rs    = 1'b1;
            wr_byte  = frame1_q[{CHAR_LAST - idx_d, 3'b000} +: 8];
         end
         ST_CHR2: begin
            wr_start = 1'b1;
            wr_rs    = 1'b1;
            wr_byte  = frame2_q[{CHAR_LAST - idx_d, 3'b000} +: 8];
         end
         default: ;
      endcase
      wr_start = wr_start && !wr_busy;
   end

   always_ff @(posedge CLK) begin
      if (CLR) begin
         state_q     <= ST_PWRUP;
         pwr_q       <= '0;
         idx_q       <= '0;
         init_done_q <= 1'b0;
         frame1_q    <= '0;
         frame2_q    <= '0;
      end else begin
         state_q     <= state_d;
         pwr_q       <= pwr_d;
         idx_q       <= idx_d;
         init_done_q <= init_done_d;
         if (state_q == ST_SNAP) begin
            frame1_q <= LINE1;
            frame2_q <= LINE2;
         end
      end
   end

   lcd_byte_writer #(
      .EN_PULSE_CYCLES  (EN_PULSE_CYCLES),
      .CMD_WAIT_CYCLES  (CMD_WAIT_CYCLES),
      .CLEAR_WAIT_CYCLES(CLEAR_WAIT_CYCLES)
   ) u_wr (
      .clk_i  (CLK),
      .clr_i  (CLR),
      .start_i(wr_start),
      .byte_i (wr_byte),
      .rs_i   (wr_rs),
      .done_o (wr_done),
      .busy_o (wr_busy),
      .data_o (LCD_DATA),
      .rs_o   (LCD_RS),
      .en_o   (LCD_EN)
   );

   assign LCD_RW     = 1'b0;
   assign LCD_ON     = 1'b1;
   assign LCD_BLON   = 1'b1;
   assign INIT_DONE  = init_done_q;
   assign FRAME_DONE = frame_done;

endmodule

// File: tb/tb_lcd_frame_writer.sv
// Directed bench for lcd_frame_writer with short timing parameters.
module tb_lcd_frame_writer;

   localparam int P_CYC = 20, N_CYC = 2, C_CYC = 5, L_CYC = 10;

   logic         CLK = 1'b0;
   logic         CLR = 1'b1;
   logic [127:0] LINE1, LINE2;
   logic [7:0]   LCD_DATA;
   logic         LCD_RS, LCD_RW, LCD_EN, LCD_ON, LCD_BLON, INIT_DONE, FRAME_DONE;

   always #5 CLK = ~CLK;

   lcd_frame_writer #(
      .POWERUP_CYCLES(P_CYC), .EN_PULSE_CYCLES(N_CYC),
      .CMD_WAIT_CYCLES(C_CYC), .CLEAR_WAIT_CYCLES(L_CYC)
   ) dut (
      .CLK(CLK), .CLR(CLR), .LINE1(LINE1), .LINE2(LINE2),
      .LCD_DATA(LCD_DATA), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_EN(LCD_EN),
      .LCD_ON(LCD_ON), .LCD_BLON(LCD_BLON), .INIT_DONE(INIT_DONE),
      .FRAME_DONE(FRAME_DONE)
   );

   int errors = 0, checks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
      checks++;
      assert (obs === req) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, req);
      end
   endtask

   // ---------------- bus monitor (samples at negedge) ----------------
   // Cycle 0 is the first cycle with CLR low after a reset edge.
   int         cyc = 0;
   logic [7:0] wd[$];
   logic       wr[$];
   int         wrise[$], wfall[$];
   int         viol = 0, init_rise = -1, fd_cnt = 0, fd_cyc = -1;
   int         en_len = 0, chg = 0;
   logic       prev_en = 0, prev_init = 0, have_last = 0, changed;
   logic [7:0] p1_d = 0, p2_d = 0, last_d = 0;
   logic       p1_rs = 0, p2_rs = 0, last_rs = 0;
   int         rise_c = 0;

   always @(negedge CLK) begin
      if (CLR) begin
         cyc = 0; wd.delete(); wr.delete(); wrise.delete(); wfall.delete();
         init_rise = -1; fd_cnt = 0; fd_cyc = -1; en_len = 0; chg = 0;
         prev_en = 0; prev_init = 0; have_last = 0;
         p1_d = 0; p2_d = 0; p1_rs = 0; p2_rs = 0;
      end else begin
         if (LCD_RW !== 1'b0) viol++;
         changed = (LCD_DATA !== p1_d) || (LCD_RS !== p1_rs);
         if (changed) chg++;
         if (LCD_EN) begin
            if (!prev_en) begin
               // SETUP cycle must show this byte; the bus may have changed
               // only once (at SETUP) since the previous write's EN fall.
               if (cyc == 0 || changed || chg > 1) viol++;
               if (have_last && (p2_d !== last_d || p2_rs !== last_rs)) viol++;
               rise_c = cyc;
               en_len = 1;
            end else begin
               en_len++;
               if (changed) viol++;
            end
         end else if (prev_en) begin
            if (en_len != N_CYC || changed) viol++;
            wd.push_back(LCD_DATA); wr.push_back(LCD_RS);
            wrise.push_back(rise_c); wfall.push_back(cyc);
            last_d = LCD_DATA; last_rs = LCD_RS; have_last = 1; chg = 0;
         end
         if (INIT_DONE && !prev_init) init_rise = cyc;
         if (FRAME_DONE) begin fd_cnt++; fd_cyc = cyc; end
         prev_init = INIT_DONE;
         prev_en = LCD_EN;
         p2_d = p1_d; p2_rs = p1_rs;
         p1_d = LCD_DATA; p1_rs = LCD_RS;
         cyc++;
      end
   end

   task automatic wait_log(input int n, input string tag);
      int k = 0;
      while (wd.size() < n && k < 3000) begin @(negedge CLK); k++; end
      chk(tag, 32'(wd.size() >= n), 32'd1);
   endtask

   task automatic wait_en(input string tag);
      int k = 0;
      do begin @(negedge CLK); k++; end while (!LCD_EN && k < 100);
      chk(tag, 32'(LCD_EN), 32'd1);
   endtask

   task automatic check_init(input string pfx);
      logic [7:0] ic [5];
      int         gap [4];
      ic = '{8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
      gap = '{C_CYC, C_CYC, C_CYC, L_CYC};
      wait_log(5, {pfx, "_init_log"});
      chk({pfx, "_first_rise"}, 32'(wrise[0]), 32'd21);
      for (int i = 0; i < 5; i++)
         chk($sformatf("%s_init%0d", pfx, i), {23'd0, wr[i], wd[i]}, {24'd0, ic[i]});
      for (int i = 0; i < 4; i++)
         chk($sformatf("%s_gap%0d", pfx, i), 32'(wrise[i+1] - 1 - wfall[i]), 32'(gap[i]));
      wait_log(6, {pfx, "_addr_log"});
      chk({pfx, "_init_done_rise"}, 32'(init_rise), 32'(wfall[4] + 5));
   endtask

   logic [7:0] e1 [16], e2 [16];

   initial begin
      e1 = '{8'h4C, 8'h6F, 8'h63, 8'h61, 8'h4C, 8'h3A, 8'h55, 8'h46,
             8'h43, 8'h47, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20};
      e2 = '{8'h44, 8'h65, 8'h73, 8'h74, 8'h69, 8'h6E, 8'h6F, 8'h3A,
             8'h43, 8'h45, 8'h4E, 8'h54, 8'h52, 8'h4F, 8'h20, 8'h20};
      LINE1 = "LocaL:UFCG      ";
      LINE2 = "Destino:CENTRO  ";
      CLR = 1'b1;
      repeat (3) @(posedge CLK);

      // reset state
      @(negedge CLK);
      chk("rst_en",    32'(LCD_EN), 32'd0);
      chk("rst_data",  32'(LCD_DATA), 32'd0);
      chk("rst_rs",    32'(LCD_RS), 32'd0);
      chk("rst_rw",    32'(LCD_RW), 32'd0);
      chk("rst_init",  32'(INIT_DONE), 32'd0);
      chk("rst_frame", 32'(FRAME_DONE), 32'd0);
      chk("lcd_on",    32'({LCD_ON, LCD_BLON}), 32'd3);
      @(posedge CLK); #1 CLR = 1'b0;

      // power-up, init sequence and its timing
      check_init("boot");

      // first frame
      wait_log(40, "frame1_log");
      chk("f1_addr1", {23'd0, wr[5], wd[5]}, 32'h080);
      for (int i = 0; i < 16; i++)
         chk($sformatf("f1_l1_%0d", i), {23'd0, wr[6+i], wd[6+i]}, {23'd0, 1'b1, e1[i]});
      chk("f1_addr2", {23'd0, wr[22], wd[22]}, 32'h0C0);
      for (int i = 0; i < 16; i++)
         chk($sformatf("f1_l2_%0d", i), {23'd0, wr[23+i], wd[23+i]}, {23'd0, 1'b1, e2[i]});
      chk("f1_done_cnt", 32'(fd_cnt), 32'd1);
      chk("f1_done_cyc", 32'(fd_cyc), 32'(wfall[38] + C_CYC - 1));
      chk("f2_addr1",    {23'd0, wr[39], wd[39]}, 32'h080);

      // input change mid-frame: frame 2 keeps its snapshot
      wait_log(45, "frame2_idx5");
      wait_en("frame2_idx5_en");
      @(posedge CLK); #1 LINE1[127:120] = 8'h41;
      wait_log(75, "frame3_log");
      chk("f2_l1_0",   {23'd0, wr[40], wd[40]}, 32'h14C);
      chk("f2_done",   32'(fd_cnt), 32'd2);
      chk("f3_addr1",  {23'd0, wr[73], wd[73]}, 32'h080);
      chk("f3_l1_0",   {23'd0, wr[74], wd[74]}, 32'h141);

      // CLR during an EN pulse of CHR2
      wait_log(95, "frame3_chr2");
      wait_en("chr2_en");
      chk("chr2_is_char", 32'(LCD_RS), 32'd1);
      @(posedge CLK); #1 CLR = 1'b1;
      @(posedge CLK); #1 CLR = 1'b0;
      @(negedge CLK);
      chk("clr_en",    32'(LCD_EN), 32'd0);
      chk("clr_data",  32'(LCD_DATA), 32'd0);
      chk("clr_rs",    32'(LCD_RS), 32'd0);
      chk("clr_init",  32'(INIT_DONE), 32'd0);
      chk("clr_frame", 32'(FRAME_DONE), 32'd0);
      check_init("replay");

      // per-write EN width / bus stability / RW, gathered by the monitor
      chk("bus_protocol_viol", 32'(viol), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
